// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg
// Shared constants for the EX->MEM stage boundary:
//   - control bit positions inside the ctrl vector
//   - payload field offsets inside the data vector
//   - state encoding of the skid-buffered stage register, {main_valid, skid_valid}
package ex_mem_pkg;

    // Control vector bit positions
    localparam int CTRL_READMEM  = 0;
    localparam int CTRL_WRITEMEM = 1;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_W        = 3;

    // Payload field offsets: addr[15:0], din[31:16], quarter[33:32], wreg[38:34]
    localparam int ADDR_LSB = 0;
    localparam int DIN_LSB  = 16;
    localparam int QTR_LSB  = 32;
    localparam int WREG_LSB = 34;
    localparam int DATA_W   = 39;

    // State encoding is {main_valid, skid_valid}; 2'b01 is illegal
    localparam logic [1:0] ENC_EMPTY = 2'b00;
    localparam logic [1:0] ENC_ONE   = 2'b10;
    localparam logic [1:0] ENC_FULL  = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = ENC_EMPTY,
        ST_ONE   = ENC_ONE,
        ST_FULL  = ENC_FULL
    } state_e;

endpackage

// File: rtl/ex_mem_skid_stage_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset, count -> 0
//   inc   - increment by one unless already at all-ones
//   clr   - synchronous clear to zero
//   count - current count value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage
// EX->MEM pipeline register with valid/ready handshake and a 2-entry skid
// buffer. in_ready comes straight from the skid-valid state bit, so the
// upstream ready path never sees the downstream out_ready combinationally.
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   in_valid/in_ready       - upstream handshake (in_ready registered)
//   in_ctrl/in_data         - control and payload from EX
//   flush                   - synchronous kill of all held entries
//   out_valid/out_ready     - downstream handshake
//   out_ctrl                - main ctrl masked by out_valid
//   out_data                - main payload, holds last value when invalid
//   clear_stats             - synchronous clear of stall_count
//   stall_count             - saturating count of out_valid & !out_ready cycles
module ex_mem_skid_stage #(
    parameter int DATA_W = ex_mem_pkg::DATA_W,
    parameter int CTRL_W = ex_mem_pkg::CTRL_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              clear_stats,
    output logic [CNT_W-1:0]  stall_count
);

    import ex_mem_pkg::*;

    state_e            r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_fire_in;
    logic w_fire_out;
    logic w_stall;

    // Valid bits are the state encoding bits themselves
    assign out_valid  = r_state[1];
    assign in_ready   = ~r_state[0];

    assign w_fire_in  = in_valid & in_ready;
    assign w_fire_out = out_valid & out_ready;
    assign w_stall    = out_valid & ~out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            // Only the valid bits clear; payload registers keep their contents
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_fire_in) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_fire_in && w_fire_out) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                    end else if (w_fire_in) begin
                        // Downstream stalled: park the new entry behind main
                        r_skid_data <= in_data;
                        r_skid_ctrl <= in_ctrl;
                        r_state     <= ST_FULL;
                    end else if (w_fire_out) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain path exists
                    if (w_fire_out) begin
                        r_main_data <= r_skid_data;
                        r_main_ctrl <= r_skid_ctrl;
                        r_state     <= ST_ONE;
                    end
                end
                default: begin
                    // Unreachable encoding (skid valid without main); recover
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    // A bubble must never assert memory or register-write controls
    assign out_ctrl = r_main_ctrl & {CTRL_W{out_valid}};
    assign out_data = r_main_data;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall),
        .clr   (clear_stats),
        .count (stall_count)
    );

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
module tb_ex_mem_skid_stage;

    localparam int DW = 39;
    localparam int CW = 3;
    localparam int NW = 8;
    localparam int CNT_MAX = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic          clear_stats = 1'b0;
    logic [NW-1:0] stall_count;

    always #5 clk = ~clk;

    ex_mem_skid_stage #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctrl     (in_ctrl),
        .in_data     (in_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_data    (out_data),
        .clear_stats (clear_stats),
        .stall_count (stall_count)
    );

    // Reference model: a FIFO of capacity 2 plus a saturating stall tally
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] m_last = '0;
    int            m_cnt  = 0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = '0;
        m_cnt  = 0;
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance model
    task automatic cycle(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                         input logic fl, input logic ordy, input logic clr);
        logic          ev;
        logic          er;
        logic [CW-1:0] ectrl;
        ent_t          e;
        @(negedge clk);
        ev    = (q.size() > 0);
        er    = (q.size() < 2);
        ectrl = '0;
        if (ev) ectrl = q[0].c;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("out_ctrl", 64'(out_ctrl), 64'(ectrl));
        chk("out_data", 64'(out_data), 64'(m_last));
        chk("stall_count", 64'(stall_count), 64'(m_cnt));
        in_valid    = iv;
        in_ctrl     = ic;
        in_data     = id;
        flush       = fl;
        out_ready   = ordy;
        clear_stats = clr;
        @(posedge clk);
        if (clr) m_cnt = 0;
        else if (ev && !ordy && m_cnt < CNT_MAX) m_cnt++;
        if (fl) begin
            q.delete();
        end else begin
            if (ev && ordy) void'(q.pop_front());
            if (iv && er) begin
                e.c = ic;
                e.d = id;
                q.push_back(e);
            end
        end
        if (q.size() > 0) m_last = q[0].d;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    initial begin
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        logic [DW-1:0] dc;
        logic [CW-1:0] rc;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and single push
        cycle(0, 3'b000, '0, 0, 1, 0);
        cycle(1, 3'b001, 39'h0_1234_ABCD, 0, 1, 0);
        #1;
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data", 64'(out_data), 64'h0_1234_ABCD);
        chk("single_ctrl", 64'(out_ctrl), 64'd1);
        cycle(0, 3'b000, '0, 0, 1, 0);
        #1;
        chk("single_drain_ctrl", 64'(out_ctrl), 64'd0);
        cycle(0, 3'b000, '0, 0, 1, 0);

        // Back-pressure: A, B, refused third, then drain in order
        da = rnd_data();
        db = rnd_data();
        dc = rnd_data();
        cycle(1, 3'b010, da, 0, 0, 0);
        cycle(1, 3'b100, db, 0, 0, 0);
        #1;
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        cycle(1, 3'b111, dc, 0, 0, 0);
        cycle(0, 3'b000, '0, 0, 0, 0);
        cycle(0, 3'b000, '0, 0, 1, 0);
        #1;
        chk("bp_second_out", 64'(out_data), 64'(db));
        cycle(0, 3'b000, '0, 0, 1, 0);
        cycle(0, 3'b000, '0, 0, 1, 1);

        // Streaming: 20 back-to-back pushes with out_ready high
        for (int i = 0; i < 20; i++) begin
            rc = 3'($urandom_range(0, 7));
            cycle(1, rc, rnd_data(), 0, 1, 0);
        end
        cycle(0, 3'b000, '0, 0, 1, 0);
        #1;
        chk("stream_stall", 64'(stall_count), 64'd0);
        cycle(0, 3'b000, '0, 0, 1, 0);

        // Flush while FULL with an offered input
        cycle(1, 3'b011, rnd_data(), 0, 0, 0);
        cycle(1, 3'b101, rnd_data(), 0, 0, 0);
        cycle(1, 3'b111, dc, 1, 0, 0);
        #1;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_ctrl", 64'(out_ctrl), 64'd0);
        cycle(0, 3'b000, '0, 0, 1, 0);

        // Stall counter saturation and clear
        cycle(0, 3'b000, '0, 0, 1, 1);
        cycle(1, 3'b001, rnd_data(), 0, 0, 0);
        for (int i = 0; i < 300; i++) cycle(0, 3'b000, '0, 0, 0, 0);
        #1;
        chk("stall_sat", 64'(stall_count), 64'd255);
        cycle(0, 3'b000, '0, 0, 0, 1);
        #1;
        chk("stall_clear", 64'(stall_count), 64'd0);
        cycle(0, 3'b000, '0, 0, 1, 0);
        cycle(0, 3'b000, '0, 0, 1, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rc = 3'($urandom_range(0, 7));
            cycle(($urandom_range(0, 3) != 0), rc, rnd_data(),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 99) == 0));
        end

        // Async reset while FULL, no clock edge needed
        cycle(1, 3'b001, rnd_data(), 0, 0, 0);
        cycle(1, 3'b010, rnd_data(), 0, 0, 0);
        cycle(1, 3'b100, rnd_data(), 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_stall", 64'(stall_count), 64'd0);
        chk("arst_ctrl", 64'(out_ctrl), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // First push after reset behaves as from EMPTY
        da = rnd_data();
        cycle(1, 3'b110, da, 0, 1, 0);
        #1;
        chk("post_rst_data", 64'(out_data), 64'(da));
        cycle(0, 3'b000, '0, 0, 1, 0);
        cycle(0, 3'b000, '0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
